// File: rtl/not16.sv
// not16 - 16-bit bitwise inverter for the LittleComputer gate library.
//
// Purpose:
//   Y and ones are purely combinational (Y = ~A, ones = popcount(Y)) and never
//   depend on clk/rst, so the gate is usable with only (Y, A) connected.
//   A registered copy of the complement (Y_r) with a one-cycle valid flag is
//   provided for pipelined consumers.
//
// Ports:
//   Y         out [15:0] combinational complement of A
//   A         in  [15:0] operand
//   clk       in         rising-edge clock (registered path only)
//   rst       in         asynchronous active-high reset of registered state
//   in_valid  in         capture strobe for the registered path
//   Y_r       out [15:0] complement of the last captured A
//   out_valid out        high for the cycle after each capture
//   ones      out [4:0]  number of 1-bits in Y (0..16)
//   xfer_cnt  out [15:0] saturating capture count (NOT16_STATS_EN only)
//
// Configuration:
//   NOT16_STATS_EN  when defined, compiles in the xfer_cnt port and counter.

module not16 (
    output logic [15:0] Y,
    input  logic [15:0] A,
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic [15:0] Y_r,
    output logic        out_valid,
    output logic [4:0]  ones
`ifdef NOT16_STATS_EN
    ,
    output logic [15:0] xfer_cnt
`endif
);

    logic [15:0] w_y;
    logic [4:0]  w_ones;
    logic [15:0] r_y;
    logic        r_vld;

    assign w_y = ~A;
    assign Y   = w_y;

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < 16; i++) begin
            w_ones = w_ones + {4'd0, w_y[i]};
        end
    end

    assign ones = w_ones;

    // Y_r holds between captures; out_valid is a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y   <= '0;
            r_vld <= 1'b0;
        end else begin
            r_vld <= in_valid;
            if (in_valid) begin
                r_y <= w_y;
            end
        end
    end

    assign Y_r       = r_y;
    assign out_valid = r_vld;

`ifdef NOT16_STATS_EN
    logic [15:0] r_cnt;

    // Saturates at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (in_valid && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign xfer_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_not16.sv
// tb_not16 - self-checking bench for not16.
//
// Directed combinational sweep and extremes, directed registered-path and
// asynchronous-reset steps, then randomized traffic checked against a
// behavioural model. With NOT16_STATS_EN, also checks the capture counter
// including saturation.

module tb_not16;

    logic [15:0] Y;
    logic [15:0] A;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] Y_r;
    logic        out_valid;
    logic [4:0]  ones;
`ifdef NOT16_STATS_EN
    logic [15:0] xfer_cnt;
`endif

    not16 dut (
        .Y         (Y),
        .A         (A),
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .Y_r       (Y_r),
        .out_valid (out_valid),
        .ones      (ones)
`ifdef NOT16_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Model state for the registered path
    logic [15:0] exp_yr;
    logic        exp_ov;
    int          exp_cnt;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Number of ones in ~a == number of zeros in a.
    function automatic int ref_ones(input logic [15:0] a);
        int c = 0;
        for (int i = 0; i < 16; i++) begin
            if (((a >> i) & 16'd1) == 16'd0) c++;
        end
        return c;
    endfunction

    task automatic chk_comb(input string tag);
        chk({tag, ".Y"}, Y, 16'hFFFF - A);
        chk({tag, ".ones"}, {11'd0, ones}, 16'(ref_ones(A)));
    endtask

    task automatic chk_reg(input string tag);
        chk({tag, ".Y_r"}, Y_r, exp_yr);
        chk({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, exp_ov});
`ifdef NOT16_STATS_EN
        chk({tag, ".xfer_cnt"}, xfer_cnt, 16'(exp_cnt));
`endif
    endtask

    // One clock: drive on the falling edge, model the rising edge, settle 1.
    task automatic cyc(input logic v, input logic [15:0] a);
        @(negedge clk);
        in_valid = v;
        A        = a;
        @(posedge clk);
        if (!rst) begin
            exp_ov = v;
            if (v) begin
                exp_yr = 16'hFFFF - a;
                if (exp_cnt < 65535) exp_cnt++;
            end
        end
        #1;
    endtask

    logic [15:0] sweep [6] = '{16'h5555, 16'hCCCC, 16'h85DD, 16'h0515, 16'h0000, 16'hFFFF};
    logic [15:0] sweep_y [6] = '{16'hAAAA, 16'h3333, 16'h7A22, 16'hFAEA, 16'hFFFF, 16'h0000};
    int          sweep_o [6] = '{8, 8, 7, 11, 16, 0};

    initial begin
        int guard;
        rst      = 1'b1;
        in_valid = 1'b0;
        A        = 16'h0000;
        exp_yr   = 16'h0000;
        exp_ov   = 1'b0;
        exp_cnt  = 0;

        #3;
        chk_reg("reset");

        // Combinational sweep: A changes every time unit.
        for (int i = 0; i < 6; i++) begin
            A = sweep[i];
            #1;
            chk($sformatf("sweep%0d.Y", i), Y, sweep_y[i]);
            chk($sformatf("sweep%0d.ones", i), {11'd0, ones}, 16'(sweep_o[i]));
        end

        @(negedge clk);
        rst = 1'b0;

        // Registered capture then hold.
        cyc(1'b1, 16'h1234);
        chk("cap", Y_r, 16'hEDCB);
        chk("cap.ov", {15'd0, out_valid}, 16'd1);
        cyc(1'b0, 16'h0F0F);
        chk("hold", Y_r, 16'hEDCB);
        chk("hold.ov", {15'd0, out_valid}, 16'd0);
        chk_comb("hold");

        // Asynchronous reset between edges, with a capture request pending.
        #2;
        rst      = 1'b1;
        in_valid = 1'b1;
        #1;
        exp_yr = 16'h0000;
        exp_ov = 1'b0;
        exp_cnt = 0;
        chk_reg("async_rst");
        chk_comb("async_rst");
        @(posedge clk);
        #1;
        chk_reg("rst_no_cap");

        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back captures after reset release.
        cyc(1'b1, 16'hA5A5);
        chk_reg("b2b0");
        cyc(1'b1, 16'h0001);
        chk_reg("b2b1");
        cyc(1'b1, 16'h8000);
        chk_reg("b2b2");
`ifdef NOT16_STATS_EN
        chk("cnt3", xfer_cnt, 16'd3);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 200; i++) begin
            cyc(1'($urandom_range(0, 1)), 16'($urandom));
            chk_reg($sformatf("rnd%0d", i));
            chk_comb($sformatf("rnd%0d", i));
        end

`ifdef NOT16_STATS_EN
        // Drive the counter to saturation and confirm it holds.
        guard = 0;
        while (exp_cnt < 65535 && guard < 70000) begin
            cyc(1'b1, 16'($urandom));
            guard++;
        end
        if (exp_cnt < 65535) chk("sat_timeout", 16'(exp_cnt), 16'hFFFF);
        chk("sat", xfer_cnt, 16'hFFFF);
        cyc(1'b1, 16'h1111);
        cyc(1'b1, 16'h2222);
        chk("sat_hold", xfer_cnt, 16'hFFFF);
        chk_reg("sat_end");
`else
        guard = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
